// File: rtl/serial_word_receiver.sv
// Packs the serial bit stream MSB-first into words and queues them in a small FWFT FIFO.
// Count is shown on an active-low seven-segment digit.
module serial_word_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SerIn,
  input  logic                     SerInValid,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         Dout,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [$clog2(WIDTH)-1:0] BitCnt,
  output logic                     FrameDone,
  output logic                     Overflow,
  output logic [6:0]               seven_segments
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] shreg;
  logic             validQ;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  logic             wordDone;
  logic             frameEnd;
  logic             pushReq;
  logic             pushOk;
  logic             pop;
  logic [BW:0]      padShift;
  logic [WIDTH-1:0] pushWord;

  // A frame-end push left-aligns the k collected bits, zero-filling the rest.
  always_comb begin
    wordDone = SerInValid && (BitCnt == BW'(WIDTH - 1));
    frameEnd = !SerInValid && validQ;
    pushReq  = wordDone || (frameEnd && (BitCnt != '0));
    padShift = (BW + 1)'(WIDTH) - {1'b0, BitCnt};
    pushWord = wordDone ? {shreg[WIDTH-2:0], SerIn} : (shreg << padShift);
    pop      = rd_en && !Empty;
    pushOk   = pushReq && (!Full || pop);
  end

  assign Dout  = mem[rdPtr];
  assign Empty = (Count == '0);
  assign Full  = (Count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      BitCnt    <= '0;
      validQ    <= 1'b0;
      FrameDone <= 1'b0;
      Overflow  <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      validQ    <= SerInValid;
      FrameDone <= frameEnd;

      if (SerInValid) begin
        shreg  <= {shreg[WIDTH-2:0], SerIn};
        BitCnt <= wordDone ? '0 : BitCnt + 1'b1;
      end else if (frameEnd && (BitCnt != '0)) begin
        shreg  <= '0;
        BitCnt <= '0;
      end

      if (pushOk) begin
        mem[wrPtr] <= pushWord;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      // A refused push loses the word for good, so remember it until reset.
      if (pushReq && !pushOk) begin
        Overflow <= 1'b1;
      end

      if (pushOk && !pop) begin
        Count <= Count + 1'b1;
      end else if (pop && !pushOk) begin
        Count <= Count - 1'b1;
      end
    end
  end

  always_comb begin
    case (int'(Count))
      0:       seven_segments = 7'b1000000;
      1:       seven_segments = 7'b1111001;
      2:       seven_segments = 7'b0100100;
      3:       seven_segments = 7'b0110000;
      4:       seven_segments = 7'b0011001;
      5:       seven_segments = 7'b0010010;
      6:       seven_segments = 7'b0000010;
      7:       seven_segments = 7'b1111000;
      8:       seven_segments = 7'b0000000;
      default: seven_segments = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_serial_word_receiver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SerIn = 1'b0;
  logic       SerInValid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] Dout;
  logic       Empty;
  logic       Full;
  logic [2:0] Count;
  logic [2:0] BitCnt;
  logic       FrameDone;
  logic       Overflow;
  logic [6:0] seven_segments;

  int checks = 0;
  int errors = 0;

  logic [6:0] segTab [0:8];

  logic [7:0] mq [$];
  int         mBits = 0;
  int         mAcc = 0;
  logic       mPrev = 1'b0;
  logic       mOver = 1'b0;
  logic       mFrame = 1'b0;
  logic       mPush = 1'b0;
  logic       mPop = 1'b0;
  logic [7:0] mWord = 8'h00;

  serial_word_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .SerIn(SerIn),
    .SerInValid(SerInValid),
    .rd_en(rd_en),
    .Dout(Dout),
    .Empty(Empty),
    .Full(Full),
    .Count(Count),
    .BitCnt(BitCnt),
    .FrameDone(FrameDone),
    .Overflow(Overflow),
    .seven_segments(seven_segments)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic rd);
    @(negedge clk);
    SerInValid = v;
    SerIn      = b;
    rd_en      = rd;
  endtask

  task automatic sendWord(input logic [7:0] w, input int nBits, input logic rdLast);
    for (int i = 0; i < nBits; i++) begin
      applyStimulus(1'b1, w[7-i], rdLast && (i == nBits - 1));
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rstEmpty", 32'(Empty), 32'd1);
    checkOutput("rstFull", 32'(Full), 32'd0);
    checkOutput("rstDout", 32'(Dout), 32'h0);
    checkOutput("rstCount", 32'(Count), 32'd0);
    checkOutput("rstBitCnt", 32'(BitCnt), 32'd0);
    checkOutput("rstFrameDone", 32'(FrameDone), 32'd0);
    checkOutput("rstOverflow", 32'(Overflow), 32'd0);
    checkOutput("rstSeg", 32'(seven_segments), 32'b1000000);
  endtask

  // Reference behaviour: bits accumulate arithmetically, words live in a queue.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mBits  = 0;
      mAcc   = 0;
      mPrev  = 1'b0;
      mOver  = 1'b0;
      mFrame = 1'b0;
    end else begin
      mPush  = 1'b0;
      mPop   = rd_en && (mq.size() > 0);
      mFrame = !SerInValid && mPrev;
      if (SerInValid) begin
        mAcc = mAcc * 2 + int'(SerIn);
        mBits++;
        if (mBits == WIDTH) begin
          mWord = 8'(mAcc);
          mPush = 1'b1;
          mBits = 0;
          mAcc  = 0;
        end
      end else if (mFrame && mBits > 0) begin
        mWord = 8'(mAcc << (WIDTH - mBits));
        mPush = 1'b1;
        mBits = 0;
        mAcc  = 0;
      end
      mPrev = SerInValid;
      if (mPop) void'(mq.pop_front());
      if (mPush) begin
        if (mq.size() < DEPTH) mq.push_back(mWord);
        else mOver = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("mdlCount", 32'(Count), 32'(mq.size()));
      checkOutput("mdlEmpty", 32'(Empty), 32'(mq.size() == 0));
      checkOutput("mdlFull", 32'(Full), 32'(mq.size() == DEPTH));
      checkOutput("mdlBitCnt", 32'(BitCnt), 32'(mBits));
      checkOutput("mdlFrameDone", 32'(FrameDone), 32'(mFrame));
      checkOutput("mdlOverflow", 32'(Overflow), 32'(mOver));
      checkOutput("mdlSeg", 32'(seven_segments), 32'(segTab[mq.size()]));
      if (mq.size() > 0) checkOutput("mdlDout", 32'(Dout), 32'(mq[0]));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int popIdx;
    logic [7:0] w;
    segTab[0] = 7'b1000000; segTab[1] = 7'b1111001; segTab[2] = 7'b0100100;
    segTab[3] = 7'b0110000; segTab[4] = 7'b0011001; segTab[5] = 7'b0010010;
    segTab[6] = 7'b0000010; segTab[7] = 7'b1111000; segTab[8] = 7'b0000000;

    #3;
    checkResetValues();
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single word 0xA5");
    sendWord(8'hA5, 8, 1'b0);
    @(posedge clk); #1;
    checkOutput("a5Dout", 32'(Dout), 32'hA5);
    checkOutput("a5Count", 32'(Count), 32'd1);
    checkOutput("a5Seg", 32'(seven_segments), 32'b1111001);
    checkOutput("a5NoFrame", 32'(FrameDone), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("a5FrameDone", 32'(FrameDone), 32'd1);
    checkOutput("a5NoExtraPush", 32'(Count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("a5FramePulse", 32'(FrameDone), 32'd0);

    $display("[TB] partial frame 1,1,0");
    sendWord(8'hC0, 3, 1'b0);
    @(posedge clk); #1;
    checkOutput("partBitCnt3", 32'(BitCnt), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("partFrameDone", 32'(FrameDone), 32'd1);
    checkOutput("partBitCnt0", 32'(BitCnt), 32'd0);
    checkOutput("partCount", 32'(Count), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("partDout", 32'(Dout), 32'hC0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("partEmpty", 32'(Empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 5; i++) begin
      w = 8'(i);
      sendWord(w, 8, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("fillFull", 32'(Full), 32'd1);
    checkOutput("fillCount", 32'(Count), 32'd4);
    checkOutput("fillOverflow", 32'(Overflow), 32'd1);
    checkOutput("fillSeg", 32'(seven_segments), 32'b0011001);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("fillOrder", 32'(Dout), 32'(i));
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    checkOutput("drainEmpty", 32'(Empty), 32'd1);
    checkOutput("overflowSticky", 32'(Overflow), 32'd1);
    #2 rst = 1'b0;
    #1 checkResetValues();
    #1 rst = 1'b1;

    $display("[TB] full with pop on completing edge");
    for (int i = 0; i < 4; i++) begin
      w = 8'(8'h11 + i);
      sendWord(w, 8, 1'b0);
    end
    sendWord(8'h55, 8, 1'b1);
    @(posedge clk); #1;
    checkOutput("swapCount", 32'(Count), 32'd4);
    checkOutput("swapOverflow", 32'(Overflow), 32'd0);
    checkOutput("swapDout", 32'(Dout), 32'h12);
    sendWord(8'hA0, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("partSwapFrame", 32'(FrameDone), 32'd1);
    checkOutput("partSwapCount", 32'(Count), 32'd4);
    checkOutput("partSwapOverflow", 32'(Overflow), 32'd0);
    checkOutput("partSwapDout", 32'(Dout), 32'h13);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-word");
    sendWord(8'h3C, 5, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkResetValues();
    #1 rst = 1'b1;
    sendWord(8'h3C, 8, 1'b0);
    @(posedge clk); #1;
    checkOutput("rstWordDout", 32'(Dout), 32'h3C);
    checkOutput("rstWordCount", 32'(Count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] wrap-around");
    popIdx = 0;
    for (int i = 0; i < 10; i++) begin
      w = 8'(8'h60 + i);
      sendWord(w, 8, 1'b0);
      @(posedge clk); #1;
      if (i % 3 != 0 && i != 9) begin
        checkOutput("wrapOrder", 32'(Dout), 32'(8'h60 + popIdx));
        applyStimulus(1'b0, 1'b0, 1'b1);
        popIdx++;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
    @(posedge clk); #1;
    checkOutput("wrapFull", 32'(Full), 32'd1);
    checkOutput("wrapOverflow", 32'(Overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("wrapDrain", 32'(Dout), 32'(8'h60 + popIdx));
      applyStimulus(1'b0, 1'b0, 1'b1);
      popIdx++;
      @(posedge clk); #1;
    end
    checkOutput("wrapEmpty", 32'(Empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Downstream consumer of the serial transmitter stage. It takes the transmitter's serial output (SerOut/SerOutValid), assembles the valid bits MSB-first into WIDTH-bit words, and buffers completed words in a small first-word-fall-through FIFO for a parallel reader. When a frame ends mid-word, the block pushes the partial word zero-padded. It drives a seven-segment digit showing the current FIFO occupancy.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- DEPTH, 4: FIFO depth in words, power of two, ≤8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- SerIn  in  1  serial data; connects to the transmitter's SerOut.
- SerInValid  in  1  SerIn qualifier; connects to SerOutValid. A high run is one frame.
- rd_en  in  1  pop the head word. Ignored while Empty.
- Dout  out  WIDTH  head word; combinational from FIFO head.
- Empty  out  1  FIFO holds no words.
- Full  out  1  FIFO holds DEPTH words.
- Count  out  $clog2(DEPTH)+1  number of words stored.
- BitCnt  out  $clog2(WIDTH)  bits collected in the current partial word.
- FrameDone  out  1  one-cycle pulse on the edge that detects the end of a frame.
- Overflow  out  1  sticky: set when a push is dropped; cleared only by reset.
- seven_segments  out  7  active-low segments {g,f,e,d,c,b,a} showing Count.

## Operation
- Reset (rst=0, asynchronous) forces the following state:
  - shift register, BitCnt, FIFO pointers, Count, FrameDone, Overflow, valid_q and all FIFO storage = 0.
  - Empty=1, Full=0, Dout=0, seven_segments=7'b1000000.
- Shift: on each edge with SerInValid=1:
  - shreg <= {shreg[WIDTH-2:0], SerIn}.
  - BitCnt <= BitCnt+1.
  - The first bit of each word ends up in the MSB.
- Word complete: on an accepted bit with BitCnt==WIDTH-1:
  - push word {shreg[WIDTH-2:0], SerIn}.
  - BitCnt <= 0.
- Frame end is detected on an edge where SerInValid=0 and valid_q=1. valid_q is SerInValid registered every cycle. On that edge:
  - FrameDone=1 for that one cycle.
  - If BitCnt=k≠0, push the k collected bits left-aligned with zeros in the low WIDTH-k bits, then set BitCnt <= 0 and shreg <= 0.
  - If BitCnt==0, no push.
- Push/pop rules:
  - A pop happens when rd_en=1 and Empty=0. The read pointer increments and the next word appears on Dout.
  - A push is accepted when Full=0, or when Full=1 and a pop occurs on the same edge.
  - A push that is not accepted is dropped and sets Overflow. The word is lost; the FIFO is unchanged.
  - Push and pop on the same edge leave Count unchanged.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH. Empty=(Count==0); Full=(Count==DEPTH).
- seven_segments decode for Count (active-low, g as MSB):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000.

## Timing
- Completed word: the last bit is sampled on edge N. Dout, Empty=0 and the updated Count are valid after edge N, with one-cycle latency from the last bit.
- Partial word: SerInValid is first sampled low on edge M. The push and FrameDone both occur on edge M.
- No back-to-back gap is required: SerInValid may stay high across word boundaries indefinitely.
- Simultaneous events:
  - A frame ending immediately after a complete word (BitCnt==0) produces only FrameDone, no extra push.
  - Frame end with a partial word plus rd_en on a full FIFO: the push is accepted.
- Reset asserted mid-word or mid-frame discards everything immediately. After release, the first bit with SerInValid=1 starts a new word at BitCnt=0.
- Dout is stable between pops. Dout is unspecified only for storage locations never written since reset; those hold 0.

## Test plan
- Default params: stream 0xA5 MSB-first with SerInValid high for 8 cycles, then low.
  - After the 8th bit edge: Dout=8'hA5, Count=1, seven_segments=1111001.
  - On the next edge: FrameDone pulses once with no further push.
- Partial frame: send 1,1,0 (3 bits), then drop SerInValid.
  - On the detecting edge: FrameDone=1, push 8'hC0, BitCnt returns to 0.
- Fill and overflow: stream 5 words 0x01..0x05 with rd_en=0.
  - Full=1, Count=4, Overflow=1; Dout=0x01 (0x05 dropped).
  - Pop 4 times: Dout sequence 0x01,0x02,0x03,0x04, then Empty=1.
- Full with simultaneous rd_en on the completing edge of word 0x55: pop and push both accepted, Count stays 4, Overflow stays 0.
- Pulse rst low asynchronously (between edges) after 5 bits of a word.
  - All outputs return to reset values immediately.
  - A following 8-bit word 0x3C is received intact.
- Wrap-around: 10 words through the FIFO with interleaved single pops. Data order is preserved and Count never exceeds 4.
